// File: rtl/id_ex_stage.sv
// ID/EX pipeline register bank for the MIPS core.
// It detects load-use hazards, inserts bubbles, honours flush and downstream
// stall, and keeps saturating bubble/flush debug counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic [1:0]        id_reg_dst,
  input  logic [3:0]        id_alu_op,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_dest;
  logic             hazard;

  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign id_rd = id_instr[15:11];

  // Destination select; the reserved encoding falls back to rt.
  always_comb begin
    id_dest = id_rt;
    case (id_reg_dst)
      2'd1:    id_dest = id_rd;
      2'd2:    id_dest = LINK_REG;
      default: id_dest = id_rt;
    endcase
  end

  // Load-use hazard against the load currently sitting in EX.
  always_comb begin
    hazard = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) &
             ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
  end

  // A flush kills the slot, so it also releases any hold on decode.
  assign id_stall = !flush & (ex_stall | hazard);

  // EX register bank with flush > stall > bubble > capture priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
      ex_shamt      <= '0;
      ex_funct      <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_pc_plus4   <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      bubble_count  <= '0;
      flush_count   <= '0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end else if (ex_stall) begin
      // hold everything
    end else if (hazard) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      if (bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      ex_valid      <= id_valid;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_dest       <= id_dest;
      ex_shamt      <= id_instr[10:6];
      ex_funct      <= id_instr[5:0];
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm_ext;
      ex_pc_plus4   <= id_pc_plus4;
      ex_reg_write  <= id_reg_write  & id_valid;
      ex_mem_read   <= id_mem_read   & id_valid;
      ex_mem_write  <= id_mem_write  & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
      ex_alu_src    <= id_alu_src    & id_valid;
      ex_alu_op     <= id_alu_op & {4{id_valid}};
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubble, flush priority,
// downstream stall, counter saturation and asynchronous reset.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4;
  logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [1:0]        id_reg_dst;
  logic [3:0]        id_alu_op;
  logic              flush, ex_stall;
  logic              id_stall, ex_valid;
  logic [4:0]        ex_rs, ex_rt, ex_dest, ex_shamt;
  logic [5:0]        ex_funct;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]        ex_alu_op;
  logic [CNT_W-1:0]  bubble_count, flush_count;

  int unsigned vectors;
  int unsigned miscompares;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_instr(id_instr), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_pc_plus4(id_pc_plus4),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .flush(flush), .ex_stall(ex_stall), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a full decode slot.
  task automatic drive(input logic [31:0] instr, input logic uses_rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic rw, input logic mr, input logic m2r,
                       input logic asrc, input logic [1:0] rdst, input logic [3:0] aop);
    id_valid = 1'b1; id_instr = instr; id_uses_rt = uses_rt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm; id_pc_plus4 = pc;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_mem_to_reg = m2r; id_alu_src = asrc; id_reg_dst = rdst; id_alu_op = aop;
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_mem_to_reg, ex_alu_src, ex_valid}, 32'd0);
    chk({tag, "_aluop"}, 32'(ex_alu_op), 32'd0);
  endtask

  localparam logic [31:0] LW_R3    = 32'h8C43_0010; // lw  r3,16(r2)
  localparam logic [31:0] LW_R0    = 32'h8C40_0010; // lw  r0,16(r2)
  localparam logic [31:0] ADD_R3   = 32'h0065_2020; // add r4,r3,r5
  localparam logic [31:0] ADD_R0   = 32'h0005_2020; // add r4,r0,r5
  localparam logic [31:0] SUB_R7   = 32'h00E8_3022; // sub r6,r7,r8

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    id_valid = 1'b0; id_instr = '0; id_uses_rt = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0; id_pc_plus4 = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_reg_dst = '0; id_alu_op = '0;
    tick(); tick();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall", 32'(id_stall), 32'd0);
    reset = 1'b0;

    // Capture of lw r3,16(r2)
    drive(LW_R3, 1'b0, 32'h1111, 32'h2222, 32'h10, 32'h104,
          1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd2);
    tick();
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_dest", 32'(ex_dest), 32'd3);
    chk("cap_rs", 32'(ex_rs), 32'd2);
    chk("cap_imm", ex_imm, 32'h10);
    chk("cap_memrd", 32'(ex_mem_read), 32'd1);
    chk("cap_pc", ex_pc_plus4, 32'h104);

    // Load-use: add r4,r3,r5 behind the lw
    drive(ADD_R3, 1'b1, 32'h3333, 32'h5555, 32'h0, 32'h108,
          1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'hA);
    #1;
    chk("lu_stall", 32'(id_stall), 32'd1);
    tick();
    chk_ctrl_zero("lu_bubble");
    chk("lu_bcount", 32'(bubble_count), 32'd1);
    chk("lu_hold_rs", 32'(ex_rs), 32'd2);
    chk("lu_release", 32'(id_stall), 32'd0);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_dest", 32'(ex_dest), 32'd4);
    chk("lu_add_rs", 32'(ex_rs), 32'd3);
    chk("lu_add_rt", 32'(ex_rt), 32'd5);
    chk("lu_add_funct", 32'(ex_funct), 32'h20);
    chk("lu_add_aluop", 32'(ex_alu_op), 32'hA);
    chk("lu_add_rsd", ex_rs_data, 32'h3333);

    // lw to r0 never creates a hazard
    drive(LW_R0, 1'b0, 32'h1, 32'h2, 32'h10, 32'h10C,
          1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd2);
    tick();
    chk("r0_dest", 32'(ex_dest), 32'd0);
    drive(ADD_R0, 1'b1, 32'h0, 32'h5, 32'h0, 32'h110,
          1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'hA);
    #1;
    chk("r0_nostall", 32'(id_stall), 32'd0);
    tick();
    chk("r0_valid", 32'(ex_valid), 32'd1);
    chk("r0_bcount", 32'(bubble_count), 32'd1);

    // Flush beats ex_stall and hazard
    drive(LW_R3, 1'b0, 32'h1111, 32'h2222, 32'h10, 32'h114,
          1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd2);
    tick();
    drive(ADD_R3, 1'b1, 32'h3333, 32'h5555, 32'h0, 32'h118,
          1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'hA);
    flush = 1'b1; ex_stall = 1'b1;
    #1;
    chk("fl_stall", 32'(id_stall), 32'd0);
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    chk_ctrl_zero("fl_slot");
    chk("fl_fcount", 32'(flush_count), 32'd1);
    chk("fl_bcount", 32'(bubble_count), 32'd1);

    // Downstream stall holds EX for 3 edges; reg_dst=2 selects r31
    drive(SUB_R7, 1'b1, 32'h7777, 32'h8888, 32'h0, 32'h11C,
          1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h6);
    tick();
    chk("st_dest31", 32'(ex_dest), 32'd31);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ADD_R3 + 32'(i), 1'b1, 32'hA000 + 32'(i), 32'hB000, 32'h0, 32'h200,
            1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h1);
      #1;
      chk("st_idstall", 32'(id_stall), 32'd1);
      tick();
      chk("st_rsd", ex_rs_data, 32'h7777);
      chk("st_rs", 32'(ex_rs), 32'd7);
      chk("st_aluop", 32'(ex_alu_op), 32'h6);
    end
    ex_stall = 1'b0;
    tick();
    chk("st_resume_rsd", ex_rs_data, 32'hA002);

    // Invalid decode slot forces control bits low
    id_valid = 1'b0;
    tick();
    chk_ctrl_zero("inv");

    // Flush counter saturates at 0xF (starts at 1)
    flush = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 13) chk("sat_e", 32'(flush_count), 32'hE);
      if (i == 14) chk("sat_f", 32'(flush_count), 32'hF);
    end
    chk("sat_hold", 32'(flush_count), 32'hF);
    chk("sat_bcount", 32'(bubble_count), 32'd1);
    flush = 1'b0;

    // Asynchronous reset mid-stall with a load in EX
    drive(LW_R3, 1'b0, 32'h1111, 32'h2222, 32'h10, 32'h300,
          1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd2);
    tick();
    chk("ar_pre", 32'(ex_valid), 32'd1);
    ex_stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_dest", 32'(ex_dest), 32'd0);
    chk("ar_imm", ex_imm, 32'd0);
    chk("ar_fcount", 32'(flush_count), 32'd0);
    chk("ar_bcount", 32'(bubble_count), 32'd0);
    chk("ar_idstall", 32'(id_stall), 32'd1);
    ex_stall = 1'b0;
    #1;
    chk("ar_idstall0", 32'(id_stall), 32'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
